// File: rtl/ds_multich_reg_bridge_pkg.sv
// Shared constants and helpers for the delta-sigma register bridge.
// Register map, control bit positions and reset values.
package ds_bridge_pkg;

   localparam int REG_SAMPLE = 0;
   localparam int REG_CTRL   = 1;
   localparam int REG_DIV    = 2;

   localparam int CTRL_RESET_LFSR   = 12;
   localparam int CTRL_FORCE_ERR    = 13;
   localparam int CTRL_DUAL_SLOPE   = 14;
   localparam int CTRL_DOUBLE_SLOPE = 15;

   localparam logic [15:0] RST_SAMPLE = 16'h8000;
   localparam logic [15:0] RST_CTRL   = 16'h0700;
   localparam logic [15:0] RST_DIV    = 16'h0000;
   localparam logic [15:0] RST_EXTRA  = 16'h0000;

   function automatic int flat_to_ch(int idx, int rpc);
      return idx / rpc;
   endfunction

   function automatic logic [15:0] reg_rst_val(int r);
      logic [15:0] v;
      v = RST_EXTRA;
      if (r == REG_SAMPLE) v = RST_SAMPLE;
      if (r == REG_CTRL)   v = RST_CTRL;
      if (r == REG_DIV)    v = RST_DIV;
      return v;
   endfunction

endpackage

// File: rtl/ds_multich_reg_bridge_if.sv
// Host/modulator-side signal bundle of the register bridge.
// The master drives the byte bus and pulse strobes; the bridge is the slave.
interface ds_multich_reg_bridge_if #(
   parameter int NUM_CH      = 2,
   parameter int REGS_PER_CH = 3
);
   localparam int NREG      = NUM_CH * REGS_PER_CH;
   localparam int ADDR_BITS = (NREG > 1) ? $clog2(NREG) : 1;

   logic [7:0]           data_in;
   logic [ADDR_BITS-1:0] addr;
   logic                 data_part_in;
   logic [NUM_CH-1:0]    pulse_done;
   logic [NREG*16-1:0]   active_regs;
   logic [NUM_CH-1:0]    pending;
   logic [NUM_CH-1:0]    pulse_toggle;
   logic                 wr_ack;

   modport master (
      output data_in, addr, data_part_in, pulse_done,
      input  active_regs, pending, pulse_toggle, wr_ack
   );

   modport slave (
      input  data_in, addr, data_part_in, pulse_done,
      output active_regs, pending, pulse_toggle, wr_ack
   );

endinterface

// File: rtl/ds_multich_reg_bridge_pulse_divider.sv
// Per-channel pulse-rate divider: toggles its output every D+1 pulses.
// The reload value is sampled only when the counter expires.
module ds_pulse_divider #(
   parameter int DIV_BITS = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pulse_i,
   input  logic [DIV_BITS-1:0] div_i,
   output logic                toggle_o
);

   logic [DIV_BITS-1:0] cnt_q, cnt_d;
   logic                tgl_q, tgl_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         tgl_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tgl_q <= tgl_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      tgl_d = tgl_q;
      if (pulse_i) begin
         if (cnt_q == '0) begin
            tgl_d = ~tgl_q;
            cnt_d = div_i;
         end else begin
            cnt_d = cnt_q - DIV_BITS'(1);
         end
      end
   end

   assign toggle_o = tgl_q;

endmodule

// File: rtl/ds_multich_reg_bridge.sv
// Host register bridge: byte-wide two-phase writes into shadow registers,
// committed to the active set only on each channel's pulse boundary.
module ds_multich_reg_bridge
   import ds_bridge_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int REGS_PER_CH = 3,
   parameter int SYNC_STAGES = 2,
   parameter int DIV_BITS    = 8
) (
   input logic                   clk,
   input logic                   reset,
   ds_multich_reg_bridge_if.slave bus
);

   localparam int NREG      = NUM_CH * REGS_PER_CH;
   localparam int ADDR_BITS = (NREG > 1) ? $clog2(NREG) : 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dp_last_q;
   logic                   dp, fall, rise;
   logic [7:0]             data_low_q;
   logic                   addr_ok, wr_evt;

   logic [15:0]       shadow_q [NREG];
   logic [15:0]       shadow_d [NREG];
   logic [15:0]       active_q [NREG];
   logic [15:0]       active_d [NREG];
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [NUM_CH-1:0] commit;
   logic [NUM_CH-1:0] toggle;
   logic              wr_ack_q;

   // Async strobe; all stages idle high so a write needs a fresh low phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q    <= '1;
         dp_last_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.data_part_in};
         dp_last_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign dp   = sync_q[SYNC_STAGES-1];
   assign fall = ~dp & dp_last_q;
   assign rise = dp & ~dp_last_q;

   always_ff @(posedge clk) begin
      if (fall) data_low_q <= bus.data_in;
   end

   assign addr_ok = 32'(bus.addr) < 32'(NREG);
   assign wr_evt  = rise & addr_ok;
   assign commit  = bus.pulse_done & pending_q;

   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q & ~commit;
      for (int i = 0; i < NREG; i++) begin
         if (commit[flat_to_ch(i, REGS_PER_CH)]) begin
            active_d[i] = shadow_q[i];
         end else if (bus.pulse_done[flat_to_ch(i, REGS_PER_CH)] &&
                      (i % REGS_PER_CH) == REG_CTRL) begin
            active_d[i][CTRL_RESET_LFSR] = 1'b0;
         end
         if (wr_evt && bus.addr == ADDR_BITS'(i)) begin
            shadow_d[i] = {bus.data_in, data_low_q};
            pending_d[flat_to_ch(i, REGS_PER_CH)] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            shadow_q[i] <= reg_rst_val(i % REGS_PER_CH);
            active_q[i] <= reg_rst_val(i % REGS_PER_CH);
         end
         pending_q <= '0;
         wr_ack_q  <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         wr_ack_q  <= wr_evt;
      end
   end

   // Divider reloads from the pre-commit active value.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_div
      ds_pulse_divider #(
         .DIV_BITS (DIV_BITS)
      ) u_div (
         .clk      (clk),
         .reset    (reset),
         .pulse_i  (bus.pulse_done[c]),
         .div_i    (active_q[c*REGS_PER_CH+REG_DIV][DIV_BITS-1:0]),
         .toggle_o (toggle[c])
      );
   end

   for (genvar i = 0; i < NREG; i++) begin : g_out
      assign bus.active_regs[16*i +: 16] = active_q[i];
   end

   assign bus.pending      = pending_q;
   assign bus.pulse_toggle = toggle;
   assign bus.wr_ack       = wr_ack_q;

endmodule

// File: tb/tb_ds_multich_reg_bridge.sv
// Directed bench for the register bridge (NUM_CH=2, REGS_PER_CH=3).
// Expected values are hand-computed per vector.
module tb_ds_multich_reg_bridge;

   localparam logic [95:0] RST_VEC =
      96'h0000_0700_8000_0000_0700_8000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   ds_multich_reg_bridge_if #(.NUM_CH(2), .REGS_PER_CH(3)) bus ();

   ds_multich_reg_bridge #(
      .NUM_CH      (2),
      .REGS_PER_CH (3),
      .SYNC_STAGES (2),
      .DIV_BITS    (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [95:0] got,
                        input logic [95:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] reg_at(int i);
      logic [95:0] v;
      v = bus.active_regs;
      return v[16*i +: 16];
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.pulse_done = '0;
      bus.data_part_in = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse(input logic [1:0] m);
      @(negedge clk);
      bus.pulse_done = m;
      @(negedge clk);
      bus.pulse_done = '0;
   endtask

   // ack0: wr_ack at the expected cycle, ack1: the cycle after
   task automatic do_write(input logic [2:0] a, input logic [15:0] d,
                           input logic [1:0] pm,
                           output logic ack0, output logic ack1);
      @(negedge clk);
      bus.addr = a;
      bus.data_in = d[7:0];
      bus.data_part_in = 1'b0;
      repeat (4) @(negedge clk);
      bus.data_in = d[15:8];
      bus.data_part_in = 1'b1;
      repeat (2) @(negedge clk);
      bus.pulse_done = pm;
      @(negedge clk);
      bus.pulse_done = '0;
      ack0 = bus.wr_ack;
      @(negedge clk);
      ack1 = bus.wr_ack;
   endtask

   logic a0, a1;
   int   acks;
   logic [8:0] tgl_exp = 9'b000111000;

   initial begin
      bus.data_in = '0;
      bus.addr = '0;
      bus.data_part_in = 1'b1;
      bus.pulse_done = '0;
      do_reset();
      check("rst_regs", bus.active_regs, RST_VEC);
      check("rst_pend", 96'(bus.pending), 96'h0);
      check("rst_tgl", 96'(bus.pulse_toggle), 96'h0);
      check("rst_ack", 96'(bus.wr_ack), 96'h0);

      do_write(3'd0, 16'h1234, 2'b00, a0, a1);
      check("w0_ack", 96'(a0), 96'h1);
      check("w0_ack_once", 96'(a1), 96'h0);
      check("w0_pend", 96'(bus.pending), 96'h1);
      check("w0_shadow_only", 96'(reg_at(0)), 96'h8000);
      pulse(2'b01);
      check("w0_commit", 96'(reg_at(0)), 96'h1234);
      check("w0_pend_clr", 96'(bus.pending), 96'h0);

      do_write(3'd3, 16'h5678, 2'b00, a0, a1);
      check("w3_ack", 96'(a0), 96'h1);
      check("w3_pend", 96'(bus.pending), 96'h2);
      pulse(2'b01);
      check("w3_no_xch", 96'(reg_at(3)), 96'h8000);
      check("w3_pend_kept", 96'(bus.pending), 96'h2);
      pulse(2'b10);
      check("w3_commit", 96'(reg_at(3)), 96'h5678);
      check("w3_pend_clr", 96'(bus.pending), 96'h0);

      do_write(3'd1, 16'h1000, 2'b01, a0, a1);
      check("ctl_ack", 96'(a0), 96'h1);
      check("ctl_hold", 96'(reg_at(1)), 96'h0700);
      check("ctl_pend", 96'(bus.pending), 96'h1);
      pulse(2'b01);
      check("ctl_commit", 96'(reg_at(1)), 96'h1000);
      pulse(2'b01);
      check("ctl_selfclr", 96'(reg_at(1)), 96'h0000);

      do_write(3'd6, 16'hABCD, 2'b00, a0, a1);
      check("oor_ack", 96'({a0, a1}), 96'h0);
      check("oor_pend", 96'(bus.pending), 96'h0);
      check("oor_regs", bus.active_regs,
            96'h0000_0700_5678_0000_0000_1234);

      do_reset();
      do_write(3'd2, 16'h0002, 2'b00, a0, a1);
      check("div_ack", 96'(a0), 96'h1);
      pulse(2'b01);
      check("div_commit", 96'(reg_at(2)), 96'h0002);
      check("div_tgl0", 96'(bus.pulse_toggle[0]), 96'h1);
      for (int k = 0; k < 9; k++) begin
         pulse(2'b01);
         check($sformatf("div_tgl_p%0d", k + 1),
               96'(bus.pulse_toggle[0]), 96'(tgl_exp[8-k]));
      end
      check("div_ch1_idle", 96'(bus.pulse_toggle[1]), 96'h0);

      // Low phase captured, then reset before the high phase.
      @(negedge clk);
      bus.addr = 3'd0;
      bus.data_in = 8'hEE;
      bus.data_part_in = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      bus.data_in = 8'h11;
      bus.data_part_in = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      acks = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.wr_ack) acks++;
      end
      check("mid_rst_ack", 96'(acks), 96'h0);
      check("mid_rst_pend", 96'(bus.pending), 96'h0);
      check("mid_rst_regs", bus.active_regs, RST_VEC);
      check("mid_rst_tgl", 96'(bus.pulse_toggle), 96'h0);

      do_write(3'd4, 16'hBEEF, 2'b00, a0, a1);
      check("post_ack", 96'(a0), 96'h1);
      check("post_pend", 96'(bus.pending), 96'h2);
      pulse(2'b10);
      check("post_commit", 96'(reg_at(4)), 96'hBEEF);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
